bcd_serial_sub: RTL

Digit-serial multi-digit BCD subtractor that computes A − B one decimal digit per clock, least-significant digit first. It complements the combinational BCD adder path as the subtraction/decrement side of the same decimal arithmetic datapath. It takes packed BCD operands under a start/done handshake and returns a packed BCD difference with a borrow flag. When A < B, the difference is returned in ten's-complement form. Invalid BCD input digits are flagged.

---
 rtl/bcd_serial_sub.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor: A - B, one decimal digit per clock, LSD first.
// Negative results come back in ten's-complement form with borrow set.
module bcd_serial_sub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          brw_q, brw_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          borrow_q, borrow_d;
  logic          err_q, err_d;

  logic          bad_in;
  logic [4:0]    t;
  logic [3:0]    dig;
  logic          last;
  logic [W-1:0]  shifted;

  // Flag any operand digit above 9 at the moment of capture
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9) bad_in = 1'b1;
      if (b[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  // One digit of subtraction; 5-bit wrap makes t[4] the sign
  always_comb begin
    t = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, brw_q};
    dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    last = (cnt_q == CW'(DIGITS - 1));
    shifted = (diff_q >> 4) | (W'(dig) << (W - 4));
  end

  // Control sequencing and datapath next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          err_d   = bad_in;
        end
      end
      S_RUN: begin
        a_d    = a_q >> 4;
        b_d    = b_q >> 4;
        brw_d  = t[4];
        diff_d = shifted;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          state_d  = S_DONE;
          borrow_d = err_q ? 1'b0 : t[4];
          diff_d   = err_q ? '0 : shifted;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign err    = err_q;

endmodule
